// File: rtl/dt_res_pack.sv
// dt_res_pack: converts the 128x128 8-bit distance-transform result back into
// the 1024x16 packed binary source-image format, one pixel per clock.
//
// state | meaning
// IDLE  | waiting for start after reset, all strobes low
// READ  | issuing result addresses 0..16383, one per cycle
// FLUSH | capturing the final pixel and emitting the last word
// FIN   | write strobe drops, done is raised at the end of this cycle
// DONE  | pass complete, ones_cnt final, start re-runs the pass
module dt_res_pack #(
  parameter logic [7:0] THRESH = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do,
  output logic        busy,
  output logic        done,
  output logic [14:0] ones_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FLUSH = 3'd2,
    FIN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Second-to-last address: issuing the last one coincides with leaving READ.
  localparam logic [13:0] PEN_ADDR = 14'd16382;
  localparam logic [14:0] ONES_MAX = 15'd16384;

  state_t      state;
  logic [15:0] shift_q;
  logic        pix_bit;
  logic        capture;
  logic        word_end;
  logic        accept;

  // Read data always belongs to the address presented in the previous cycle,
  // which is still on res_addr at the capturing edge, so res_addr doubles as
  // the pixel index of the value on res_di.
  always_comb begin
    pix_bit  = (res_di > THRESH);
    capture  = (state == READ) || (state == FLUSH);
    word_end = capture && (res_addr[3:0] == 4'hF);
    accept   = start && ((state == IDLE) || (state == DONE));
  end

  // Sequencer: address generation, pass status and state transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      res_rd   <= 1'b0;
      res_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state    <= READ;
            res_rd   <= 1'b1;
            res_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        READ: begin
          res_addr <= res_addr + 14'd1;
          if (res_addr == PEN_ADDR) begin
            res_rd <= 1'b0;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          state <= FIN;
        end
        FIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: threshold, shift-in from the LSB, word emit and ones count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      ones_cnt <= '0;
      sti_wr   <= 1'b0;
      sti_addr <= '0;
      sti_do   <= '0;
    end else begin
      sti_wr <= 1'b0;
      if (accept) begin
        shift_q  <= '0;
        ones_cnt <= '0;
      end else if (capture) begin
        shift_q <= {shift_q[14:0], pix_bit};
        if (pix_bit && (ones_cnt != ONES_MAX)) begin
          ones_cnt <= ones_cnt + 15'd1;
        end
      end
      if (word_end) begin
        sti_do   <= {shift_q[14:0], pix_bit};
        sti_addr <= res_addr[13:4];
        sti_wr   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dt_res_pack.sv
// Bench for dt_res_pack: two instances (THRESH 0 and 3) share one result
// memory; a cycle-indexed model predicts every output after each edge.
module tb_dt_res_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rd0, rd3, wr0, wr3, busy0, busy3, done0, done3;
  logic [13:0] addr0, addr3;
  logic [7:0]  di0, di3;
  logic [9:0]  sa0, sa3;
  logic [15:0] do0, do3;
  logic [14:0] ones0, ones3;

  dt_res_pack #(.THRESH(8'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(rd0), .res_addr(addr0), .res_di(di0),
    .sti_wr(wr0), .sti_addr(sa0), .sti_do(do0),
    .busy(busy0), .done(done0), .ones_cnt(ones0)
  );

  dt_res_pack #(.THRESH(8'd3)) dut3 (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(rd3), .res_addr(addr3), .res_di(di3),
    .sti_wr(wr3), .sti_addr(sa3), .sti_do(do3),
    .busy(busy3), .done(done3), .ones_cnt(ones3)
  );

  always #5 clk = ~clk;

  logic [7:0]  pix [16384];
  logic [15:0] smem0 [1024];
  logic [15:0] smem3 [1024];
  int          wcnt0 = 0;
  int          wcnt3 = 0;

  // Result memory: address sampled on the falling edge.
  always @(negedge clk) begin
    di0 = pix[addr0];
    di3 = pix[addr3];
  end

  // Packed-image memories commit on the rising edge.
  always @(posedge clk) begin
    if (wr0) begin
      smem0[sa0] <= do0;
      wcnt0 <= wcnt0 + 1;
    end
    if (wr3) begin
      smem3[sa3] <= do3;
      wcnt3 <= wcnt3 + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: k = edges since the accepting edge E0.
  bit          m_started;
  int          k;
  int          m_ones0, m_ones3;
  int          h_addr;
  logic [15:0] h_do0, h_do3;
  int          pref0 [16385];
  int          pref3 [16385];

  function automatic logic [15:0] exp_word(input int w, input logic [7:0] thr);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[15-j] = (pix[16*w+j] > thr);
    return r;
  endfunction

  function automatic logic [58:0] pk(input logic rd, input logic [13:0] a, input logic wr,
                                     input logic [9:0] sa, input logic [15:0] d,
                                     input logic b, input logic dn, input logic [14:0] o);
    return {rd, a, wr, sa, d, b, dn, o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < 16384; i++) begin
      case (mode)
        0: pix[i] = 8'd0;
        1: pix[i] = 8'd1;
        2: pix[i] = (i % 2 == 1) ? 8'd5 : 8'd0;
        3: pix[i] = 8'(i % 256);
        default: pix[i] = 8'($urandom_range(0, 255));
      endcase
    end
    pref0[0] = 0;
    pref3[0] = 0;
    for (int i = 0; i < 16384; i++) begin
      pref0[i+1] = pref0[i] + ((pix[i] > 8'd0) ? 1 : 0);
      pref3[i+1] = pref3[i] + ((pix[i] > 8'd3) ? 1 : 0);
    end
  endtask

  task automatic model_step();
    int kc;
    if (!reset) begin
      m_started = 0; k = 0; m_ones0 = 0; m_ones3 = 0;
      h_addr = 0; h_do0 = '0; h_do3 = '0;
      return;
    end
    if (start && (!m_started || k >= 16385)) begin
      m_started = 1;
      k = 0;
    end else if (m_started && k < 16385) begin
      k++;
    end else begin
      return;
    end
    kc = (k > 16384) ? 16384 : k;
    m_ones0 = pref0[kc];
    m_ones3 = pref3[kc];
    if (k >= 16 && k <= 16384 && k % 16 == 0) begin
      h_addr = k / 16 - 1;
      h_do0 = exp_word(h_addr, 8'd0);
      h_do3 = exp_word(h_addr, 8'd3);
    end
  endtask

  task automatic check_cycle();
    logic e_rd, e_wr, e_busy, e_done;
    logic [13:0] e_addr;
    e_rd   = m_started && (k < 16383);
    e_addr = m_started ? 14'((k > 16383) ? 16383 : k) : 14'd0;
    e_wr   = m_started && (k >= 16) && (k <= 16384) && (k % 16 == 0);
    e_busy = m_started && (k <= 16384);
    e_done = m_started && (k >= 16385);
    chk("cycle outputs thr0",
        64'(pk(rd0, addr0, wr0, sa0, do0, busy0, done0, ones0)),
        64'(pk(e_rd, e_addr, e_wr, 10'(h_addr), h_do0, e_busy, e_done, 15'(m_ones0))));
    chk("cycle outputs thr3",
        64'(pk(rd3, addr3, wr3, sa3, do3, busy3, done3, ones3)),
        64'(pk(e_rd, e_addr, e_wr, 10'(h_addr), h_do3, e_busy, e_done, 15'(m_ones3))));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_pass(input bit repulse, output int lat);
    int e0;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    lat = -1;
    for (int i = 0; i < 17000; i++) begin
      if (done0 && done3) begin
        lat = cyc - e0;
        break;
      end
      start = repulse && ((cyc - e0) == 99 || (cyc - e0) == 8999 || (cyc - e0) == 16384);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic post_pass(input string nm, input int lat, input int w0, input int w3,
                           input logic [15:0] word0_0, input logic [15:0] word0_3,
                           input int o0, input int o3);
    int bad0, bad3;
    chk({nm, " done latency"}, 64'(lat), 64'd16385);
    chk({nm, " write count thr0"}, 64'(wcnt0 - w0), 64'd1024);
    chk({nm, " write count thr3"}, 64'(wcnt3 - w3), 64'd1024);
    chk({nm, " word0 thr0"}, 64'(smem0[0]), 64'(word0_0));
    chk({nm, " word0 thr3"}, 64'(smem3[0]), 64'(word0_3));
    chk({nm, " ones thr0"}, 64'(ones0), 64'(o0));
    chk({nm, " ones thr3"}, 64'(ones3), 64'(o3));
    bad0 = 0;
    bad3 = 0;
    for (int w = 0; w < 1024; w++) begin
      if (smem0[w] !== exp_word(w, 8'd0)) bad0++;
      if (smem3[w] !== exp_word(w, 8'd3)) bad3++;
    end
    chk({nm, " bad words thr0"}, 64'(bad0), 64'd0);
    chk({nm, " bad words thr3"}, 64'(bad3), 64'd0);
  endtask

  initial begin
    int lat, w0, w3, e0, bad;
    reset = 1'b0;
    start = 1'b0;
    load(0);
    model_step();
    repeat (3) tick();
    chk("reset outputs thr0", 64'(pk(rd0, addr0, wr0, sa0, do0, busy0, done0, ones0)), 64'd0);
    reset = 1'b1;
    repeat (3) tick();

    // All zero: THRESH 0 and 3 both give 0x0000.
    w0 = wcnt0; w3 = wcnt3;
    run_pass(1'b0, lat);
    post_pass("zeros", lat, w0, w3, 16'h0000, 16'h0000, 0, 0);
    repeat ($urandom_range(1, 6)) tick();

    // All 0x01 with ignored start pulses mid-pass and during FIN.
    load(1);
    w0 = wcnt0; w3 = wcnt3;
    run_pass(1'b1, lat);
    post_pass("ones", lat, w0, w3, 16'hFFFF, 16'h0000, 16384, 0);
    repeat ($urandom_range(1, 6)) tick();

    // Odd pixels 5, even pixels 0.
    load(2);
    w0 = wcnt0; w3 = wcnt3;
    run_pass(1'b0, lat);
    post_pass("alternate", lat, w0, w3, 16'h5555, 16'h5555, 8192, 8192);
    repeat ($urandom_range(1, 6)) tick();

    // Random image, reset dropped just after E0+5000.
    load(4);
    w0 = wcnt0; w3 = wcnt3;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    while (cyc - e0 < 4999) tick();
    @(posedge clk);
    cyc++;
    model_step();
    #2;
    reset = 1'b0;
    model_step();
    #1;
    chk("abort zero thr0", 64'(pk(rd0, addr0, wr0, sa0, do0, busy0, done0, ones0)), 64'd0);
    chk("abort zero thr3", 64'(pk(rd3, addr3, wr3, sa3, do3, busy3, done3, ones3)), 64'd0);
    @(negedge clk);
    check_cycle();
    repeat (4) tick();
    reset = 1'b1;
    repeat ($urandom_range(2, 6)) tick();
    chk("abort write count thr0", 64'(wcnt0 - w0), 64'd312);
    chk("abort write count thr3", 64'(wcnt3 - w3), 64'd312);
    bad = 0;
    for (int w = 0; w < 312; w++) begin
      if (smem0[w] !== exp_word(w, 8'd0)) bad++;
      if (smem3[w] !== exp_word(w, 8'd3)) bad++;
    end
    chk("abort kept words", 64'(bad), 64'd0);
    chk("abort word312 thr0", 64'(smem0[312]), 64'h5555);
    chk("abort word312 thr3", 64'(smem3[312]), 64'h5555);

    // Ramp i mod 256, full pass after the reset.
    load(3);
    w0 = wcnt0; w3 = wcnt3;
    run_pass(1'b0, lat);
    post_pass("ramp", lat, w0, w3, 16'h7FFF, 16'h0FFF, 16320, 16128);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
